// File: rtl/rr_stream_mux.sv
// N-to-1 stream mux with round-robin arbitration; 1-cycle latency, full throughput, holds output under backpressure.
// Define RR_STREAM_MUX_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module rr_stream_mux #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N*W-1:0]                      in_data,
  input  logic [N-1:0]                        in_valid,
  output logic [N-1:0]                        in_ready,
  output logic [W-1:0]                        out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_ch
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic          load_en;
  logic          found;
  logic [CW-1:0] gnt_idx;
  int            idx;

  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
  logic [CW-1:0] ptr_q, ptr_d;
`endif

  assign load_en = !out_valid_q || out_ready;

  // Search order starts at ptr and wraps; fixed-priority build always starts at 0.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
      idx = i;
`else
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
`endif
      if (!found && in_valid[CW'(idx)]) begin
        found   = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
  end

  assign in_ready = (load_en && !rst && found) ? (N'(1) << gnt_idx) : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (load_en) begin
      if (found) begin
        out_data_d  = in_data[gnt_idx*W +: W];
        out_valid_d = 1'b1;
        out_ch_d    = gnt_idx;
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
        ptr_d       = (gnt_idx == CW'(N-1)) ? '0 : gnt_idx + CW'(1);
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 SHALL have parameter N, default 8, number of input channels (legal 2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (legal 1..64).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 in_data  input  N*W  channel i data at bits [i*W +: W].
REQ-007 in_valid  input  N  channel i holds a word.
REQ-008 in_ready  output  N  channel i word accepted this cycle when in_valid[i] and in_ready[i] are both high.
REQ-009 out_data  output  W  registered selected word.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
REQ-012 out_ch  output  max(1,$clog2(N))  registered index of the channel that supplied out_data.

Function
REQ-013 SHALL define load_en = !out_valid || out_ready, combinationally.
REQ-014 SHALL assert at most one in_ready bit per cycle, and only when load_en=1 and rst=0.
REQ-015 SHALL grant, when load_en=1, the first channel with in_valid set, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-016 SHALL assert no in_ready bit when no in_valid bit is set.
REQ-017 SHALL, on a grant to channel g: load out_data=in_data[g], out_ch=g, out_valid=1 next edge, and set ptr=(g+1) mod N, wrapping N-1 to 0.
REQ-018 SHALL, when load_en=1 and no grant occurs: set out_valid=0 next edge and leave ptr, out_data and out_ch unchanged.
REQ-019 SHALL hold out_data, out_ch and out_valid stable while out_valid=1 and out_ready=0 (backpressure), and assert no in_ready.
REQ-020 SHALL accept a new word in the same cycle the held word drains (out_valid & out_ready), giving 1 word/cycle sustained throughput.
REQ-021 SHALL give latency of exactly 1 cycle from input handshake to out_valid.
REQ-022 SHALL make in_ready depend only on in_valid, out_valid, out_ready, ptr and rst; in_data SHALL not affect it.
REQ-023 SHALL give a single requester repeated grants every cycle while out_ready=1.
REQ-024 SHALL give each of k continuously requesting channels exactly one grant in any k consecutive grants.

Reset
REQ-025 SHALL, with rst=1 at an edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-026 SHALL hold all in_ready=0 while rst=1, combinationally.
REQ-027 SHALL discard a word held under backpressure when reset is asserted mid-operation; that word is not replayed.

Configuration
REQ-028 SHALL honour the macro RR_STREAM_MUX_FIXED_PRIO_EN.
REQ-029 With RR_STREAM_MUX_FIXED_PRIO_EN defined: the lowest-index valid channel SHALL always win, and ptr SHALL be absent or constant 0.
REQ-030 Without RR_STREAM_MUX_FIXED_PRIO_EN: round-robin per REQ-015 to REQ-017 SHALL apply.
REQ-031 Ports, latency and reset behaviour SHALL be identical in both builds.

Verification (N=4, W=8 unless stated)
REQ-032 Reset then in_valid=0001, in_data ch0=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=0; in_ready=0001 on the request cycle.
REQ-033 All in_valid=1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; exactly one in_ready bit high each cycle.
REQ-034 Word 0x3C from ch2 loaded, then out_ready=0 for 5 cycles -> out_data=0x3C, out_ch=2, out_valid=1 held throughout; in_ready=0000 throughout; on release, the next grant goes to ch3 if valid.
REQ-035 ptr=3 (after a ch2 grant), in_valid=1001 -> ch3 granted, then ch0; ptr wraps to 0 after the ch3 grant.
REQ-036 Backpressure holding 0x77, then rst=1 for one cycle -> out_valid=0, out_data=0, out_ch=0 after the edge; in_ready=0000 during rst; the first grant after reset goes to the lowest valid index at or above 0.
REQ-037 Build with RR_STREAM_MUX_FIXED_PRIO_EN, in_valid=0110, out_ready=1 for 4 cycles -> out_ch=1 every cycle; ch2 never granted.
